// File: rtl/led_panel_pkg.sv
// Shared types and geometry for the LED panel read-side scanner.
package led_panel_pkg;

    localparam int DEF_COL_BITS   = 5;
    localparam int DEF_ROW_BITS   = 4;
    localparam int DEF_COLOR_BITS = 8;

    typedef enum logic [2:0] {
        S_TOP,
        S_BOT,
        S_CAP,
        S_SHIFT,
        S_WAIT,
        S_LATCH
    } scan_state_t;

    function automatic logic [31:0] pixel_addr(
        input logic        half,
        input logic [15:0] row,
        input logic [15:0] col,
        input int          row_bits,
        input int          col_bits
    );
        return ({31'd0, half} << (row_bits + col_bits))
             | ({16'd0, row} << col_bits)
             | {16'd0, col};
    endfunction

endpackage

// File: rtl/bcm_display_timer.sv
// Binary-weighted display counter and active-low output enable.
module bcm_display_timer #(
    parameter int BASE_TIME = 16,
    parameter int PLANE_W   = 3,
    parameter int CNT_W     = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [PLANE_W-1:0] plane,
    input  logic               force_blank,
    output logic               disp_zero,
    output logic               panel_oe_n
);

    logic [CNT_W-1:0] disp_cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = disp_cnt;
        if (load)
            cnt_next = CNT_W'(BASE_TIME) << plane;
        else if (disp_cnt != '0)
            cnt_next = disp_cnt - 1'b1;
    end

    assign disp_zero = (disp_cnt == '0);

    // oe_n is registered from the next count so the lit window matches it exactly
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_cnt   <= '0;
            panel_oe_n <= 1'b1;
        end else begin
            disp_cnt   <= cnt_next;
            panel_oe_n <= force_blank || (cnt_next == '0);
        end
    end

endmodule

// File: rtl/led_panel_scanner.sv
// HUB75 scan engine: reads frame memory, shifts bit planes, BCM display.
module led_panel_scanner
    import led_panel_pkg::*;
#(
    parameter int COL_BITS   = DEF_COL_BITS,
    parameter int ROW_BITS   = DEF_ROW_BITS,
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int BASE_TIME  = 16,
    parameter int ADDR_LINES = 1 + ROW_BITS + COL_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic [ADDR_LINES-1:0] Address_b,
    input  logic [COLOR_BITS-1:0] RedOut_b,
    input  logic [COLOR_BITS-1:0] GreenOut_b,
    input  logic [COLOR_BITS-1:0] BlueOut_b,
    output logic                  panel_r1,
    output logic                  panel_g1,
    output logic                  panel_b1,
    output logic                  panel_r2,
    output logic                  panel_g2,
    output logic                  panel_b2,
    output logic                  panel_clk,
    output logic                  panel_lat,
    output logic                  panel_oe_n,
    output logic [ROW_BITS-1:0]   panel_addr,
    output logic                  frame_done
);

    localparam int PLANE_W = $clog2(COLOR_BITS);
    localparam int CNT_W   = $clog2(BASE_TIME) + COLOR_BITS;
    localparam logic [PLANE_W-1:0]  LAST_PLANE = PLANE_W'(COLOR_BITS - 1);
    localparam logic [COL_BITS-1:0] COL_MAX    = '1;
    localparam logic [ROW_BITS-1:0] ROW_MAX    = '1;

    if (ADDR_LINES != 1 + ROW_BITS + COL_BITS) begin : g_bad_addr
        $error("ADDR_LINES must equal 1+ROW_BITS+COL_BITS");
    end

    scan_state_t         state;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [PLANE_W-1:0]  plane;
    logic [2:0]          top_hold;
    logic                disp_zero;
    logic                latch_go;
    logic [COL_BITS-1:0] col_inc;
    logic [ROW_BITS-1:0] row_inc;

    function automatic logic [ADDR_LINES-1:0] addr_of(
        input logic                half,
        input logic [ROW_BITS-1:0] r,
        input logic [COL_BITS-1:0] c
    );
        return ADDR_LINES'(pixel_addr(half, 16'(r), 16'(c),
                                      ROW_BITS, COL_BITS));
    endfunction

    assign latch_go = (state == S_WAIT) && disp_zero && enable;
    assign col_inc  = col + 1'b1;
    assign row_inc  = row + 1'b1;

    bcm_display_timer #(
        .BASE_TIME (BASE_TIME),
        .PLANE_W   (PLANE_W),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .load        (state == S_LATCH),
        .plane       (plane),
        .force_blank (latch_go),
        .disp_zero   (disp_zero),
        .panel_oe_n  (panel_oe_n)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_TOP;
            col        <= '0;
            row        <= '0;
            plane      <= '0;
            top_hold   <= '0;
            Address_b  <= '0;
            panel_r1   <= 1'b0;
            panel_g1   <= 1'b0;
            panel_b1   <= 1'b0;
            panel_r2   <= 1'b0;
            panel_g2   <= 1'b0;
            panel_b2   <= 1'b0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_addr <= '0;
            frame_done <= 1'b0;
        end else begin
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                S_TOP: begin
                    state     <= S_BOT;
                    Address_b <= addr_of(1'b1, row, col);
                end
                S_BOT: begin
                    state    <= S_CAP;
                    top_hold <= {RedOut_b[plane], GreenOut_b[plane],
                                 BlueOut_b[plane]};
                end
                S_CAP: begin
                    state <= S_SHIFT;
                    {panel_r1, panel_g1, panel_b1} <= top_hold;
                    {panel_r2, panel_g2, panel_b2} <=
                        {RedOut_b[plane], GreenOut_b[plane],
                         BlueOut_b[plane]};
                end
                S_SHIFT: begin
                    panel_clk <= 1'b1;
                    col       <= col_inc;
                    Address_b <= addr_of(1'b0, row, col_inc);
                    state     <= (col == COL_MAX) ? S_WAIT : S_TOP;
                end
                S_WAIT: begin
                    // row changes while the panel is blanked by force_blank
                    if (latch_go) begin
                        state      <= S_LATCH;
                        panel_lat  <= 1'b1;
                        panel_addr <= row;
                        frame_done <= (row == ROW_MAX)
                                   && (plane == LAST_PLANE);
                    end
                end
                S_LATCH: begin
                    state <= S_TOP;
                    if (plane == LAST_PLANE) begin
                        plane     <= '0;
                        row       <= row_inc;
                        Address_b <= addr_of(1'b0, row_inc, col);
                    end else begin
                        plane     <= plane + 1'b1;
                        Address_b <= addr_of(1'b0, row, col);
                    end
                end
                default: state <= S_TOP;
            endcase
        end
    end

endmodule

// File: tb/tb_led_panel_scanner.sv
// Directed + random-memory bench for led_panel_scanner with a timing model.
module tb_led_panel_scanner;

    localparam int COL_BITS   = 5;
    localparam int ROW_BITS   = 4;
    localparam int COLOR_BITS = 8;
    localparam int BASE_TIME  = 16;
    localparam int ADDR_LINES = 1 + ROW_BITS + COL_BITS;
    localparam int COLS       = 1 << COL_BITS;
    localparam int ROWS       = 1 << ROW_BITS;

    logic                  clock;
    logic                  reset;
    logic                  enable;
    logic [ADDR_LINES-1:0] Address_b;
    logic [COLOR_BITS-1:0] RedOut_b, GreenOut_b, BlueOut_b;
    logic panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2;
    logic panel_clk, panel_lat, panel_oe_n, frame_done;
    logic [ROW_BITS-1:0]   panel_addr;

    logic [23:0] mem [0:(1<<ADDR_LINES)-1];
    logic [23:0] rd;

    int n_assert = 0;
    int n_fail   = 0;
    int t, g, k, last_lat, last_disp, oe_run, frames, runs2048;
    bit lat_timed;
    int gsave;

    led_panel_scanner #(
        .COL_BITS   (COL_BITS),
        .ROW_BITS   (ROW_BITS),
        .COLOR_BITS (COLOR_BITS),
        .BASE_TIME  (BASE_TIME),
        .ADDR_LINES (ADDR_LINES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .Address_b  (Address_b),
        .RedOut_b   (RedOut_b),
        .GreenOut_b (GreenOut_b),
        .BlueOut_b  (BlueOut_b),
        .panel_r1   (panel_r1),
        .panel_g1   (panel_g1),
        .panel_b1   (panel_b1),
        .panel_r2   (panel_r2),
        .panel_g2   (panel_g2),
        .panel_b2   (panel_b2),
        .panel_clk  (panel_clk),
        .panel_lat  (panel_lat),
        .panel_oe_n (panel_oe_n),
        .panel_addr (panel_addr),
        .frame_done (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // memory with one cycle of read latency, colour packed as {B,G,R}
    always @(posedge clock) rd <= mem[Address_b];
    assign RedOut_b   = rd[7:0];
    assign GreenOut_b = rd[15:8];
    assign BlueOut_b  = rd[23:16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; g = 0; k = 0; last_lat = -1; last_disp = 0;
        oe_run = 0; lat_timed = 1'b1;
    endtask

    // panel-level expectations: what each shift/latch must show
    task automatic observe();
        int pl, rw, at, ab, exp_lat;
        logic [23:0] wt, wb;
        pl = g % COLOR_BITS;
        rw = (g / COLOR_BITS) % ROWS;
        if (!panel_oe_n) oe_run++;
        else if (oe_run > 0) begin
            chk("oe_len", oe_run, last_disp);
            if (oe_run == 2048) runs2048++;
            oe_run = 0;
        end
        if (panel_clk) begin
            at = (rw << COL_BITS) | k;
            ab = (1 << (ROW_BITS + COL_BITS)) | at;
            wt = mem[at];
            wb = mem[ab];
            chk("shift_time", t, last_lat + 5 + 4 * k);
            chk("shift_data",
                {panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2},
                {wt[pl], wt[8+pl], wt[16+pl], wb[pl], wb[8+pl], wb[16+pl]});
            k++;
        end
        if (panel_lat) begin
            exp_lat = last_lat + ((last_disp + 2 > 4 * COLS + 2) ?
                                  last_disp + 2 : 4 * COLS + 2);
            chk("lat_cols", k, COLS);
            if (lat_timed) chk("lat_time", t, exp_lat);
            chk("lat_addr", panel_addr, rw);
            chk("lat_oe", panel_oe_n, 1);
            chk("lat_frame_done", frame_done,
                (rw == ROWS - 1) && (pl == COLOR_BITS - 1));
            if (frame_done) frames++;
            last_lat  = t;
            last_disp = BASE_TIME << pl;
            lat_timed = 1'b1;
            g++;
            k = 0;
        end else if (frame_done) begin
            chk("stray_frame_done", frame_done, 0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        t++;
        observe();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_LINES); i++) mem[i] = 24'($urandom());
        mem[0]      = 24'h000001;
        mem[10'h200] = 24'h010000;
        frames = 0; runs2048 = 0;
        reset = 1'b1; enable = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
            chk("rst_oe_n", panel_oe_n, 1);
            chk("rst_outs", {Address_b, panel_r1, panel_g1, panel_b1,
                             panel_r2, panel_g2, panel_b2, panel_clk,
                             panel_lat, panel_addr, frame_done}, 0);
        end
        reset = 1'b0;
        model_reset();
        chk("addr_c0", Address_b, 10'h000);
        tick();
        chk("addr_c1", Address_b, 10'h200);
        tick();
        tick();
        chk("col0_data", {panel_r1, panel_g1, panel_b1,
                          panel_r2, panel_g2, panel_b2}, 6'b100001);
        chk("col0_clk_low", panel_clk, 0);
        tick();
        chk("col0_clk", panel_clk, 1);

        for (int i = 0; i < 72000 && g < 129; i++) tick();
        chk("frame_latches", g, 129);
        chk("frame_pulses", frames, 1);
        chk("long_plane_seen", runs2048 > 0, 1);

        for (int i = 0; i < 3000 && g < 134; i++) tick();
        chk("reach_plane5", g, 134);
        repeat (140) tick();
        enable = 1'b0;
        gsave = g;
        for (int i = 0; i < 600 && !panel_oe_n; i++) tick();
        chk("oe_off_stalled", panel_oe_n, 1);
        chk("no_lat_stall", g, gsave);
        repeat (20) tick();
        chk("blank_hold", panel_oe_n, 1);
        chk("no_lat_hold", g, gsave);
        lat_timed = 1'b0;
        enable = 1'b1;
        tick();
        chk("lat_after_enable", panel_lat, 1);

        repeat (3) tick();
        chk("lit_before_reset", panel_oe_n, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("oe_after_reset", panel_oe_n, 1);
        chk("addr_after_reset", Address_b, 0);
        reset = 1'b0;
        model_reset();
        chk("restart_addr0", Address_b, 10'h000);
        tick();
        chk("restart_addr1", Address_b, 10'h200);
        for (int i = 0; i < 300 && g < 1; i++) tick();
        chk("restart_latch", g, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
